// File: rtl/word_serializer_pkg.sv
// word_serializer_pkg
//   Shared definitions for the word serializer and its bit counter.
//   - State encoding as plain 2-bit constants.
//   - cnt_w(): width of the bit-position counter for a given word size.

package word_serializer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Width of the bit-position counter. It counts 0..SIZE-1, so
    // $clog2(SIZE) bits are enough. SIZE is at least 2, so the result is at least 1.
    function automatic int cnt_w(input int size);
        return $clog2(size);
    endfunction

endpackage

// File: rtl/word_serializer_bit_counter.sv
// word_serializer_bit_counter
//   Up-counter with synchronous clear, enable and a terminal-count flag.
//   The counter stops at TERM: when the enable is asserted at terminal
//   count, the value holds. It therefore never wraps.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous, active-high reset; clears the count
//   clr    synchronous clear; has priority over en
//   en     count enable
//   tc     high while count == TERM

module word_serializer_bit_counter #(
    parameter int WIDTH = 4,
    parameter int TERM  = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign tc = (count_q == TERM_V);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/word_serializer.sv
// word_serializer
//   Parallel-to-serial read-out stage. The block accepts one SIZE-bit word
//   through a load/ready handshake. It then shifts the word out one bit per
//   cycle with valid/last framing. The receiver can freeze the current bit
//   with stall. After the final bit has been consumed, the block pulses
//   done for one cycle.
//
// Parameters
//   SIZE       word width in bits (>= 2)
//   MSB_FIRST  1: bit SIZE-1 goes out first; 0: bit 0 goes out first
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous, active-high reset (priority over load/stall)
//   inData  parallel word, sampled only on the accepting edge
//   load    request to accept inData (only honoured in IDLE)
//   ready   high when a load will be accepted
//   stall   receiver hold; freezes the current bit during SHIFT
//   sOut    serial data bit, forced to 0 when sValid is low
//   sValid  sOut carries a valid bit
//   last    current bit is the final bit of the word
//   done    one-cycle pulse after the final bit is consumed
//
// States
//   IDLE  | waiting for load; ready=1
//   SHIFT | presenting bits on sOut; sValid=1
//   DONE  | one-cycle done pulse, then back to IDLE

module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] inData,
    input  logic            load,
    output logic            ready,
    input  logic            stall,
    output logic            sOut,
    output logic            sValid,
    output logic            last,
    output logic            done
);

    localparam int CW = cnt_w(SIZE);

    state_t          state_q;
    state_t          state_d;
    logic [SIZE-1:0] shreg_q;
    logic [SIZE-1:0] shreg_d;
    logic [SIZE-1:0] shreg_shifted;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;

    // Shift toward the output end and fill the vacated bit with zero.
    assign shreg_shifted = MSB_FIRST ? {shreg_q[SIZE-2:0], 1'b0}
                                     : {1'b0, shreg_q[SIZE-1:1]};

    // The counter advances once per consumed bit. It is cleared when a word
    // is accepted, so that every word starts from bit position 0.
    assign cnt_en = (state_q == ST_SHIFT) && !stall;

    word_serializer_bit_counter #(
        .WIDTH (CW),
        .TERM  (SIZE - 1)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shreg_d = inData;
                    cnt_clr = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!stall) begin
                    if (cnt_tc) begin
                        state_d = ST_DONE;
                    end else begin
                        shreg_d = shreg_shifted;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    // All outputs are decoded from registered state only.
    assign ready  = (state_q == ST_IDLE);
    assign sValid = (state_q == ST_SHIFT);
    assign sOut   = sValid && (MSB_FIRST ? shreg_q[SIZE-1] : shreg_q[0]);
    assign last   = sValid && cnt_tc;
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer. It uses two instances: a 16-bit
// MSB-first instance and an 8-bit LSB-first instance. Inputs change 1 ns
// after each rising edge, and outputs are sampled at that same point.

module tb_word_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] in_data;
    logic        load;
    logic        stall;
    logic        ready, s_out, s_valid, last, done;

    logic [7:0]  in8;
    logic        load8;
    logic        stall8;
    logic        ready8, s_out8, s_valid8, last8, done8;

    int runs  = 0;
    int fails = 0;

    word_serializer #(.SIZE(16), .MSB_FIRST(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .inData (in_data),
        .load   (load),
        .ready  (ready),
        .stall  (stall),
        .sOut   (s_out),
        .sValid (s_valid),
        .last   (last),
        .done   (done)
    );

    word_serializer #(.SIZE(8), .MSB_FIRST(1'b0)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .inData (in8),
        .load   (load8),
        .ready  (ready8),
        .stall  (stall8),
        .sOut   (s_out8),
        .sValid (s_valid8),
        .last   (last8),
        .done   (done8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; stall = 1'b0; in_data = '0;
        load8 = 1'b0; stall8 = 1'b0; in8 = '0;
        tick(); tick();
        rst = 1'b0;
        runs++;
        if ({ready, s_valid, s_out, last, done} !== 5'b10000) begin
            fails++;
            $display("FAIL reset16: rdy/vld/out/last/done=%b expected 10000",
                     {ready, s_valid, s_out, last, done});
        end
        runs++;
        if ({ready8, s_valid8, s_out8, last8, done8} !== 5'b10000) begin
            fails++;
            $display("FAIL reset8: rdy/vld/out/last/done=%b expected 10000",
                     {ready8, s_valid8, s_out8, last8, done8});
        end
        // Stall has no effect while idle.
        stall = 1'b1;
        tick();
        stall = 1'b0;
        runs++;
        if ({ready, s_valid, done} !== 3'b100) begin
            fails++;
            $display("FAIL idle_stall: rdy/vld/done=%b expected 100", {ready, s_valid, done});
        end
    endtask

    task automatic test_msb_first();
        logic [15:0] w;
        w = 16'hA5C3;
        in_data = w; load = 1'b1;
        tick();
        load = 1'b0; in_data = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            runs++;
            if ({s_valid, s_out, last, ready} !== {1'b1, w[15-i], (i == 15), 1'b0}) begin
                fails++;
                $display("FAIL msb_bit%0d: vld/out/last/rdy=%b expected %b", i,
                         {s_valid, s_out, last, ready}, {1'b1, w[15-i], (i == 15), 1'b0});
            end
            tick();
        end
        runs++;
        if ({done, s_valid, s_out, ready} !== 4'b1000) begin
            fails++;
            $display("FAIL msb_done: done/vld/out/rdy=%b expected 1000", {done, s_valid, s_out, ready});
        end
        tick();
        runs++;
        if ({done, ready} !== 2'b01) begin
            fails++;
            $display("FAIL msb_idle: done/rdy=%b expected 01", {done, ready});
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        w = 8'h01;
        in8 = w; load8 = 1'b1;
        tick();
        load8 = 1'b0; in8 = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            runs++;
            if ({s_valid8, s_out8, last8} !== {1'b1, w[i], (i == 7)}) begin
                fails++;
                $display("FAIL lsb_bit%0d: vld/out/last=%b expected %b", i,
                         {s_valid8, s_out8, last8}, {1'b1, w[i], (i == 7)});
            end
            tick();
        end
        runs++;
        if ({done8, s_valid8} !== 2'b10) begin
            fails++;
            $display("FAIL lsb_done: done/vld=%b expected 10", {done8, s_valid8});
        end
        tick();
        runs++;
        if ({done8, ready8} !== 2'b01) begin
            fails++;
            $display("FAIL lsb_idle: done/rdy=%b expected 01", {done8, ready8});
        end
    endtask

    task automatic test_stall();
        logic [15:0] w;
        int b;
        int stall_left;
        int cyc;
        bit seen_done;
        w = 16'hA5C3;
        b = 0; stall_left = 3; cyc = 1; seen_done = 1'b0;
        in_data = w; load = 1'b1;
        tick();
        load = 1'b0;
        while (cyc <= 40 && !seen_done) begin
            if (done) begin
                seen_done = 1'b1;
            end else begin
                runs++;
                if (b > 15 || {s_valid, s_out, last} !== {1'b1, w[15-b], (b == 15)}) begin
                    fails++;
                    $display("FAIL stall_bit%0d cyc%0d: vld/out/last=%b", b, cyc,
                             {s_valid, s_out, last});
                end
                if (b == 4 && stall_left > 0) begin
                    stall = 1'b1;
                    stall_left--;
                end else begin
                    stall = 1'b0;
                    b++;
                end
                tick();
                cyc++;
            end
        end
        stall = 1'b0;
        // Unstalled, done appears at cycle 17; three stall cycles push it to 20.
        runs++;
        if (!seen_done || cyc != 20 || b != 16) begin
            fails++;
            $display("FAIL stall_done: seen=%0d cycle=%0d bits=%0d expected 1/20/16",
                     seen_done, cyc, b);
        end
        tick();
    endtask

    task automatic test_load_busy();
        logic [15:0] w;
        w = 16'hA5C3;
        in_data = w; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3 || i == 4) begin
                in_data = 16'hFFFF; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            runs++;
            if ({s_valid, s_out, ready} !== {1'b1, w[15-i], 1'b0}) begin
                fails++;
                $display("FAIL busy_bit%0d: vld/out/rdy=%b expected %b", i,
                         {s_valid, s_out, ready}, {1'b1, w[15-i], 1'b0});
            end
            tick();
        end
        load = 1'b0;
        runs++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL busy_done: done=%b expected 1", done);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [15:0] w;
        bit bad;
        w = 16'hA5C3;
        in_data = w; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        runs++;
        if ({s_valid, s_out} !== {1'b1, w[8]}) begin
            fails++;
            $display("FAIL rstmid_bit7: vld/out=%b expected %b", {s_valid, s_out}, {1'b1, w[8]});
        end
        rst = 1'b1; stall = 1'b1; load = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0; load = 1'b0;
        runs++;
        if ({ready, s_valid, done, s_out} !== 4'b1000) begin
            fails++;
            $display("FAIL rstmid_after: rdy/vld/done/out=%b expected 1000",
                     {ready, s_valid, done, s_out});
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done || s_valid || !ready) bad = 1'b1;
            tick();
        end
        runs++;
        if (bad) begin
            fails++;
            $display("FAIL rstmid_quiet: activity after reset got=1 expected 0");
        end
        w = 16'h8001;
        in_data = w; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            runs++;
            if ({s_valid, s_out, last} !== {1'b1, w[15-i], (i == 15)}) begin
                fails++;
                $display("FAIL rstmid_new_bit%0d: vld/out/last=%b expected %b", i,
                         {s_valid, s_out, last}, {1'b1, w[15-i], (i == 15)});
            end
            tick();
        end
        runs++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_new_done: done=%b expected 1", done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] w1;
        logic [15:0] w2;
        w1 = 16'h0F0F;
        w2 = 16'hF0F0;
        in_data = w1; load = 1'b1;
        tick();
        in_data = w2;
        for (int i = 0; i < 16; i++) begin
            runs++;
            if ({s_valid, s_out, last} !== {1'b1, w1[15-i], (i == 15)}) begin
                fails++;
                $display("FAIL b2b_w1_bit%0d: vld/out/last=%b expected %b", i,
                         {s_valid, s_out, last}, {1'b1, w1[15-i], (i == 15)});
            end
            tick();
        end
        runs++;
        if ({done, ready, s_valid} !== 3'b100) begin
            fails++;
            $display("FAIL b2b_done: done/rdy/vld=%b expected 100", {done, ready, s_valid});
        end
        tick();
        runs++;
        if ({done, ready, s_valid} !== 3'b010) begin
            fails++;
            $display("FAIL b2b_idle: done/rdy/vld=%b expected 010", {done, ready, s_valid});
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            runs++;
            if ({s_valid, s_out, last} !== {1'b1, w2[15-i], (i == 15)}) begin
                fails++;
                $display("FAIL b2b_w2_bit%0d: vld/out/last=%b expected %b", i,
                         {s_valid, s_out, last}, {1'b1, w2[15-i], (i == 15)});
            end
            if (i == 0) load = 1'b0;
            tick();
        end
        runs++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_w2_done: done=%b expected 1", done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_stall();
        test_load_busy();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", runs, fails);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-to-serial read-out stage; the opposite direction of the team's parallel-load register.
- Accepts one SIZE-bit word through a load/ready handshake and shifts it out one bit per cycle with a valid/last framing.
- Supports receiver back-pressure through stall.
- Sits between datapath result registers and a narrow serial consumer such as a debug or test port.

Parameters:
- SIZE, 16, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = bit SIZE-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- inData  input  SIZE  parallel word to serialize
- load  input  1  request to accept inData
- ready  output  1  high when a load will be accepted
- stall  input  1  receiver hold; freezes the current bit
- sOut  output  1  serial data bit; 0 when sValid=0
- sValid  output  1  sOut carries a valid bit
- last  output  1  current bit is the final bit of the word
- done  output  1  one-cycle pulse after the final bit is consumed

Behaviour:
- One clock domain. Reset is synchronous and active-high. All state changes happen on the rising edge of clk.
- FSM states: IDLE, SHIFT, DONE. All outputs are decoded from registered state and the shift register.
- Reset: at an edge with rst=1, state goes to IDLE, shift register and counter clear to 0, and any word in flight is discarded.
  - After that edge: ready=1, sValid=0, sOut=0, last=0, done=0.
  - rst has priority over load and stall.
- IDLE:
  - ready=1.
  - If load=1, the edge captures inData into the shift register, sets count=0, and moves to SHIFT.
  - If load=0, stay in IDLE.
- SHIFT:
  - ready=0, sValid=1.
  - sOut = shreg[SIZE-1] when MSB_FIRST=1, else shreg[0].
  - last=1 exactly when count==SIZE-1.
  - stall=1: shift register and count hold, and sOut/last stay stable.
  - stall=0 and count<SIZE-1: shift by one toward the output end (fill with 0), count+1.
  - stall=0 and count==SIZE-1: move to DONE.
- DONE: ready=0, sValid=0, done=1 for exactly one cycle, then unconditionally return to IDLE.
- load is ignored outside IDLE. inData is sampled only on the accepting edge; later changes to inData have no effect.
- Latency:
  - First bit is valid in the cycle after the accepting edge.
  - The last bit is consumed SIZE non-stalled SHIFT cycles later.
  - done follows in the next cycle.
  - Minimum period between accepted words is SIZE+2 cycles, with no stall.
- Counter width is $clog2(SIZE). The counter never exceeds SIZE-1, so there is no wrap-around.
- stall has no effect in IDLE or DONE.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - a CNT_W function or constant equal to $clog2(SIZE).
- One natural sub-module: bit_counter.
  - Parameterized width, synchronous clear, enable, terminal-count output.
  - Instantiated with terminal value SIZE-1; its enable is state==SHIFT && !stall.
- The shift register and FSM stay in word_serializer.

Test Plan:
- Basic MSB-first: SIZE=16, MSB_FIRST=1, load with inData=16'hA5C3, no stall.
  - Expect sOut sequence 1010_0101_1100_0011 over 16 cycles with sValid=1.
  - Expect last=1 only on the 16th bit, done pulse on the next cycle, ready=1 the cycle after done.
- LSB-first: SIZE=8, MSB_FIRST=0, inData=8'h01.
  - Expect sOut = 1,0,0,0,0,0,0,0, last on the 8th bit, then one done pulse.
- Stall: with inData=16'hA5C3, hold stall=1 for 3 cycles while on bit 4.
  - Expect sOut/last/sValid frozen for those 3 cycles.
  - Expect the full 16-bit sequence intact, with done arriving 3 cycles later than in the unstalled case.
- Load while busy: during SHIFT, pulse load with inData=16'hFFFF.
  - Expect ready=0 and the sequence unchanged.
  - Expect 16'hFFFF never to appear on sOut.
- Reset mid-operation: assert rst on bit 7 for one cycle.
  - After that edge expect ready=1, sValid=0, done=0, with no done pulse for the aborted word.
  - A new load of 16'h8001 then serializes correctly.
- Back-to-back: hold load=1 continuously with inData=16'h0F0F then 16'hF0F0.
  - Expect the second word accepted exactly in the IDLE cycle after done, giving an 18-cycle period.
  - Expect both sequences correct.
